// File: rtl/host_monitor.sv
// host_monitor: observation-only snooper on the core's data-memory write port.
// Turns putchar writes into a buffered character stream and latches a
// pass/fail/exit/timeout verdict from signature, tohost and watchdog events.
module host_monitor #(
    parameter logic [31:0]        PUTCHAR_ADDR   = 32'h1000_0000,
    parameter logic [31:0]        SIGNATURE_ADDR = 32'h1000_1000,
    parameter logic [31:0]        TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [7:0]         PASS_CODE      = 8'h03,
    parameter int                 FIFO_AW        = 4,
    parameter int                 CYCLE_W        = 32,
    parameter logic [CYCLE_W-1:0] TIMEOUT_CYCLES = CYCLE_W'(5000000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_valid,
    input  logic               bus_write,
    input  logic [3:0]         bus_wmask,
    input  logic [31:0]        bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic               restart,
    output logic               char_valid,
    output logic [7:0]         char_data,
    input  logic               char_ready,
    output logic [15:0]        char_dropped,
    output logic               done,
    output logic [2:0]         result,
    output logic [7:0]         exit_code,
    output logic [CYCLE_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_PASS    = 3'd1,
        S_FAIL    = 3'd2,
        S_EXIT    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;

    state_t             state_reg;
    logic               done_reg;
    logic [7:0]         exit_code_reg;
    logic [CYCLE_W-1:0] cycles_reg;
    logic [15:0]        dropped_reg;

    logic [FIFO_AW:0]   wr_ptr_reg;
    logic [FIFO_AW:0]   rd_ptr_reg;
    logic [7:0]         mem [DEPTH];

    // Only byte lane 0 carries meaning for every register we snoop.
    logic unused_bits;
    assign unused_bits = ^{bus_wmask[3:1], bus_wdata[31:8]};

    logic qw;
    logic sig_hit;
    logic tohost_hit;
    logic putchar_hit;
    assign qw          = bus_valid & bus_write & bus_wmask[0];
    assign sig_hit     = qw && (bus_addr == SIGNATURE_ADDR);
    // Overlapping address parameters resolve SIGNATURE > TOHOST > PUTCHAR.
    assign tohost_hit  = qw && (bus_addr == TOHOST_ADDR) && !sig_hit;
    assign putchar_hit = qw && (bus_addr == PUTCHAR_ADDR) && !sig_hit &&
                         (bus_addr != TOHOST_ADDR) && (state_reg == S_RUN);

    logic [CYCLE_W-1:0] cycles_inc;
    logic               timeout_hit;
    assign cycles_inc  = (cycles_reg == {CYCLE_W{1'b1}}) ? cycles_reg
                                                          : cycles_reg + CYCLE_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != '0) && (cycles_inc == TIMEOUT_CYCLES);

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic drop;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                        (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    assign pop        = !fifo_empty && char_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = putchar_hit && !restart && (!fifo_full || pop);
    assign drop       = putchar_hit && !restart && fifo_full && !pop;

    assign char_valid   = !fifo_empty;
    // Show-ahead head needs an asynchronous read, so this maps to LUT RAM.
    assign char_data    = fifo_empty ? 8'h00 : mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign char_dropped = dropped_reg;
    assign done         = done_reg;
    assign result       = state_reg;
    assign exit_code    = exit_code_reg;
    assign cycles       = cycles_reg;

    // Verdict FSM with cycle counter; everything except RUN is terminal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_RUN;
            done_reg      <= 1'b0;
            exit_code_reg <= 8'h00;
            cycles_reg    <= '0;
        end else if (restart) begin
            state_reg     <= S_RUN;
            done_reg      <= 1'b0;
            exit_code_reg <= 8'h00;
            cycles_reg    <= '0;
        end else if (state_reg == S_RUN) begin
            cycles_reg <= cycles_inc;
            if (sig_hit) begin
                state_reg     <= (bus_wdata[7:0] == PASS_CODE) ? S_PASS : S_FAIL;
                done_reg      <= 1'b1;
                exit_code_reg <= bus_wdata[7:0];
            end else if (tohost_hit) begin
                state_reg     <= S_EXIT;
                done_reg      <= 1'b1;
                exit_code_reg <= bus_wdata[7:0];
            end else if (timeout_hit) begin
                state_reg     <= S_TIMEOUT;
                done_reg      <= 1'b1;
                exit_code_reg <= 8'h00;
            end
        end
    end

    // Character storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= bus_wdata[7:0];
        end
    end

    // FIFO pointers and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            dropped_reg <= 16'h0000;
        end else if (restart) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            dropped_reg <= 16'h0000;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop && (dropped_reg != 16'hFFFF)) begin
                dropped_reg <= dropped_reg + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_host_monitor.sv
// Bench for host_monitor: instance a (4-deep FIFO, watchdog off) covers the
// character stream and verdicts; instance b (watchdog at 10) covers timeout.
module tb_host_monitor;

    localparam logic [31:0] PUTCHAR = 32'h1000_0000;
    localparam logic [31:0] SIG     = 32'h1000_1000;
    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam int          DEPTH_A = 4;

    logic        clk;
    logic        rst;
    logic        bus_valid;
    logic        bus_write;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        restart_a;
    logic        restart_b;
    logic        char_ready;

    logic        a_char_valid;
    logic [7:0]  a_char_data;
    logic [15:0] a_char_dropped;
    logic        a_done;
    logic [2:0]  a_result;
    logic [7:0]  a_exit_code;
    logic [31:0] a_cycles;

    logic        b_char_valid;
    logic [7:0]  b_char_data;
    logic [15:0] b_char_dropped;
    logic        b_done;
    logic [2:0]  b_result;
    logic [7:0]  b_exit_code;
    logic [31:0] b_cycles;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic        exp_run = 1'b1;
    logic [15:0] exp_drop = 16'h0000;

    host_monitor #(.FIFO_AW(2), .TIMEOUT_CYCLES(32'd0)) u_a (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_write(bus_write),
        .bus_wmask(bus_wmask), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .restart(restart_a), .char_valid(a_char_valid), .char_data(a_char_data),
        .char_ready(char_ready), .char_dropped(a_char_dropped), .done(a_done),
        .result(a_result), .exit_code(a_exit_code), .cycles(a_cycles)
    );

    host_monitor #(.TIMEOUT_CYCLES(32'd10)) u_b (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_write(bus_write),
        .bus_wmask(bus_wmask), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .restart(restart_b), .char_valid(b_char_valid), .char_data(b_char_data),
        .char_ready(1'b1), .char_dropped(b_char_dropped), .done(b_done),
        .result(b_result), .exit_code(b_exit_code), .cycles(b_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every byte leaving instance a is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && a_char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
                check("char_unexpected", {24'h0, a_char_data}, 32'hFFFF_FFFF);
            end else begin
                $display("char out %02h", a_char_data);
                check("char", {24'h0, a_char_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one bus write for a cycle and predicts its effect on instance a.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bit pop_now;
        pop_now = char_ready && (exp_q.size() > 0);
        if (mask[0] && exp_run) begin
            if (addr == SIG || addr == TOHOST) begin
                exp_run = 1'b0;
            end else if (addr == PUTCHAR) begin
                if (exp_q.size() < DEPTH_A || pop_now) exp_q.push_back(data[7:0]);
                else if (exp_drop != 16'hFFFF) exp_drop++;
            end
        end
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_wmask = mask;
        bus_addr  = addr;
        bus_wdata = data;
        step(1);
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_wmask = 4'b0000;
    endtask

    task automatic restart_dut_a();
        restart_a = 1'b1;
        step(1);
        restart_a = 1'b0;
        exp_run  = 1'b1;
        exp_drop = 16'h0000;
        exp_q.delete();
    endtask

    task automatic restart_dut_b();
        restart_b = 1'b1;
        step(1);
        restart_b = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_valid"},   {31'h0, a_char_valid}, 32'h0);
        check({tag, "_data"},    {24'h0, a_char_data},  32'h0);
        check({tag, "_dropped"}, {16'h0, a_char_dropped}, 32'h0);
        check({tag, "_done"},    {31'h0, a_done},       32'h0);
        check({tag, "_result"},  {29'h0, a_result},     32'h0);
        check({tag, "_exit"},    {24'h0, a_exit_code},  32'h0);
        check({tag, "_cycles"},  a_cycles,              32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_wmask = 4'b0000;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        restart_a = 1'b0;
        restart_b = 1'b0;
        char_ready = 1'b1;
        #1;
        check_reset_a("por");
        step(2);
        rst = 1'b0;

        // Timeout: the 10th RUN edge latches TIMEOUT with cycles = 10.
        restart_dut_b();
        step(9);
        check("to_pre_result", {29'h0, b_result}, 32'd0);
        check("to_pre_cycles", b_cycles, 32'd9);
        step(1);
        check("to_result", {29'h0, b_result}, 32'd4);
        check("to_done", {31'h0, b_done}, 32'd1);
        check("to_cycles", b_cycles, 32'd10);
        check("to_exit", {24'h0, b_exit_code}, 32'h0);
        step(3);
        check("to_frozen", b_cycles, 32'd10);

        // A tohost write on the 10th edge beats the watchdog.
        restart_dut_b();
        step(9);
        bus_wr(TOHOST, 32'h0000_002A, 4'b0001);
        check("toh_result", {29'h0, b_result}, 32'd3);
        check("toh_exit", {24'h0, b_exit_code}, 32'h2A);
        check("toh_cycles", b_cycles, 32'd10);

        // Putchar ordering, one cycle latency each.
        restart_dut_a();
        bus_wr(PUTCHAR, 32'h0000_0048, 4'b0001);
        check("hi_lat0", {31'h0, a_char_valid}, 32'd1);
        bus_wr(PUTCHAR, 32'h0000_0069, 4'b0001);
        check("hi_lat1", {31'h0, a_char_valid}, 32'd1);
        bus_wr(PUTCHAR, 32'h0000_000A, 4'b0001);
        check("hi_lat2", {31'h0, a_char_valid}, 32'd1);
        step(1);
        check("hi_drained", {31'h0, a_char_valid}, 32'd0);
        bus_wr(PUTCHAR, 32'h0000_0055, 4'b0010);
        check("lane1_ignored", {31'h0, a_char_valid}, 32'd0);
        step(8);
        check("no_watchdog", {29'h0, a_result}, 32'd0);

        // Pass, then fail after restart; putchars ignored once latched.
        restart_dut_a();
        bus_wr(SIG, 32'h0000_0003, 4'b0001);
        check("pass_result", {29'h0, a_result}, 32'd1);
        check("pass_done", {31'h0, a_done}, 32'd1);
        check("pass_exit", {24'h0, a_exit_code}, 32'h03);
        restart_dut_a();
        check("rs_result", {29'h0, a_result}, 32'd0);
        check("rs_done", {31'h0, a_done}, 32'd0);
        bus_wr(SIG, 32'h0000_0007, 4'b0001);
        check("fail_result", {29'h0, a_result}, 32'd2);
        check("fail_exit", {24'h0, a_exit_code}, 32'h07);
        check("fail_cycles", a_cycles, 32'd1);
        bus_wr(PUTCHAR, 32'h0000_0041, 4'b0001);
        check("late_putchar", {31'h0, a_char_valid}, 32'd0);
        check("frozen_cycles", a_cycles, 32'd1);

        // Overflow: four stored, two dropped, then push during pop on full.
        char_ready = 1'b0;
        restart_dut_a();
        for (int i = 0; i < 6; i++) bus_wr(PUTCHAR, 32'h61 + i, 4'b0001);
        check("ovf_dropped", {16'h0, a_char_dropped}, {16'h0, exp_drop});
        check("ovf_dropped2", {16'h0, a_char_dropped}, 32'd2);
        check("ovf_head", {24'h0, a_char_data}, 32'h61);
        char_ready = 1'b1;
        bus_wr(PUTCHAR, 32'h0000_0067, 4'b0001);
        check("ovf_push_pop", {16'h0, a_char_dropped}, 32'd2);
        step(5);
        check("ovf_empty", {31'h0, a_char_valid}, 32'd0);
        check("ovf_empty_data", {24'h0, a_char_data}, 32'h0);
        check("ovf_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset with three bytes queued.
        char_ready = 1'b0;
        restart_dut_a();
        for (int i = 0; i < 3; i++) bus_wr(PUTCHAR, 32'h31 + i, 4'b0001);
        check("pre_rst_valid", {31'h0, a_char_valid}, 32'd1);
        check("pre_rst_cycles", a_cycles, 32'd3);
        #2 rst = 1'b1;
        #1;
        check_reset_a("arst");
        exp_q.delete();
        step(1);
        rst = 1'b0;
        char_ready = 1'b1;

        // Restart wins over a signature write in the same cycle.
        step(2);
        restart_a = 1'b1;
        bus_wr(SIG, 32'h0000_0003, 4'b0001);
        restart_a = 1'b0;
        exp_run = 1'b1;
        check("rs_sig_result", {29'h0, a_result}, 32'd0);
        check("rs_sig_cycles", a_cycles, 32'd0);
        check("rs_sig_done", {31'h0, a_done}, 32'd0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_monitor.md
# host_monitor

Synthesizable bus-snooping test-harness monitor for the RudolV simulation and FPGA test flow. Watches the core's data-memory write port, and turns the putchar, signature and tohost writes into a buffered character stream plus a latched pass/fail/exit/timeout verdict. It sits beside `Memory32` on the pipeline's `mem_*` bus, is observation-only and never stalls the core. It adds a character FIFO with backpressure, drop accounting, a cycle counter, a timeout watchdog and a restart mode.

## Interface
Parameters:
- `PUTCHAR_ADDR`, 32'h1000_0000, byte address of the character output register
- `SIGNATURE_ADDR`, 32'h1000_1000, byte address of the pass/fail signature register
- `TOHOST_ADDR`, 32'h0000_1000, byte address of the tohost exit register
- `PASS_CODE`, 8'h03, low byte written to `SIGNATURE_ADDR` that means pass
- `FIFO_AW`, 4, log2 of character FIFO depth (depth 16); legal range 1..8
- `CYCLE_W`, 32, width of the cycle counter
- `TIMEOUT_CYCLES`, 5000000, watchdog limit in cycles; 0 disables the watchdog

Ports:
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, asynchronous, active-high
- `bus_valid` input 1: memory access valid
- `bus_write` input 1: access is a write
- `bus_wmask` input 4: byte write enables
- `bus_addr` input 32: byte address
- `bus_wdata` input 32: write data
- `restart` input 1: synchronous restart of the verdict and counters
- `char_valid` output 1: FIFO head is valid
- `char_data` output 8: FIFO head byte
- `char_ready` input 1: consumer accepts the head
- `char_dropped` output 16: saturating count of characters lost to a full FIFO
- `done` output 1: verdict latched
- `result` output 3: 0 RUN, 1 PASS, 2 FAIL, 3 EXIT, 4 TIMEOUT
- `exit_code` output 8: `bus_wdata[7:0]` of the terminating write
- `cycles` output CYCLE_W: cycles spent in RUN

## Operation
- Qualified write (`qw`): `bus_valid & bus_write & bus_wmask[0]`. The address compare uses all 32 bits. Other byte lanes are ignored.
- Verdict FSM has states RUN, PASS, FAIL, EXIT and TIMEOUT. Only RUN has outgoing transitions; all others are terminal until `restart` or `rst`.
- RUN → PASS: `qw` to `SIGNATURE_ADDR` with `wdata[7:0]==PASS_CODE`.
- RUN → FAIL: `qw` to `SIGNATURE_ADDR` with any other value.
- RUN → EXIT: `qw` to `TOHOST_ADDR`.
- RUN → TIMEOUT: `TIMEOUT_CYCLES!=0` and the incremented `cycles` equals `TIMEOUT_CYCLES`.
- Priority within one cycle: `restart` > SIGNATURE match > TOHOST match > timeout. If two address parameters are equal, SIGNATURE wins over TOHOST, and TOHOST wins over PUTCHAR.
- On entering any terminal state, `exit_code` takes `bus_wdata[7:0]`; for TIMEOUT it takes 8'h00.
- `done` = (`result`!=0). It is registered, not derived combinationally from the bus.
- `cycles` increments every cycle in RUN, saturates at all-ones and freezes outside RUN.
- A putchar is a `qw` to `PUTCHAR_ADDR` while in RUN. It pushes `wdata[7:0]`. Putchars are ignored once a verdict is latched, but the FIFO keeps draining.
- FIFO is show-ahead: `char_valid` = not empty, and `char_data` = head byte, forced to 8'h00 when empty. Pop when `char_valid & char_ready`.
- Push with the FIFO full and no pop in the same cycle: the byte is dropped and `char_dropped` increments, saturating at 16'hFFFF.
- Push with the FIFO full and a pop in the same cycle: the byte is accepted and the count is unchanged.
- `restart` does all of the following in one cycle:
  - result → RUN
  - `cycles`, `exit_code` and `char_dropped` → 0
  - FIFO flushed
  - the current bus cycle is ignored
- `rst` mid-operation: identical to the reset values below, applied immediately (asynchronous).

## Timing
- Reset values: `char_valid` 0, `char_data` 8'h00, `char_dropped` 0, `done` 0, `result` 0, `exit_code` 0, `cycles` 0.
- A qualified write sampled at edge N has these effects after edge N (latency 1):
  - `result`, `done` and `exit_code` are updated.
  - A putchar into an empty FIFO raises `char_valid`.
- Pop at edge N: the next head, or empty, is visible after edge N. No combinational path from `char_ready` to `char_valid`.
- The bus is never backpressured; every bus cycle is sampled exactly once.
- Timeout: with `TIMEOUT_CYCLES`=T, the T-th RUN edge after reset release latches TIMEOUT, and `cycles`=T from then on.
- Throughput: one push and one pop per cycle sustained. The FIFO holds 2^FIFO_AW entries, all usable.

## Test plan
- Putchar ordering: writes of "Hi\n" to 32'h1000_0000 with `wmask`=4'b0001, `char_ready`=1 → bytes 8'h48, 8'h69, 8'h0A out in order, each one cycle after its write. A write with `wmask`=4'b0010 produces nothing.
- Pass and fail: write 32'h0000_0003 to 32'h1000_1000 → `result`=1, `done`=1, `exit_code`=8'h03. After `restart`, writing 32'h0000_0007 gives `result`=2 and `exit_code`=8'h07. A later putchar is ignored.
- Overflow: `FIFO_AW`=2, `char_ready`=0, six putchars 'a'..'f' → FIFO holds 'a'..'d' and `char_dropped`=2. A putchar in the same cycle as a pop on a full FIFO is accepted with no extra drop.
- Timeout vs. write: `TIMEOUT_CYCLES`=10, no writes → `result`=4 and `cycles`=10 after the 10th edge. Repeat with a tohost write on the 10th edge → `result`=3.
- Reset and restart: assert `rst` mid-stream with 3 bytes queued → all outputs at reset values immediately, with no clock edge needed. `restart` in the same cycle as a signature write → `result`=0 and `cycles`=0.
